// File: rtl/byte_lane_memory_if.sv
// Request/response bus for byte_lane_memory: valid/ready request channel
// plus a registered response channel carrying read data and an error flag.
`default_nettype none

interface byte_lane_memory_if #(
    parameter int unsigned WORD_BYTES = 4
) ();
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [WORD_BYTES-1:0]     req_be;
    logic [31:0]               req_addr;
    logic [WORD_BYTES*8-1:0]   req_wdata;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [WORD_BYTES*8-1:0]   resp_rdata;
    logic                      resp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

`default_nettype wire

// File: rtl/byte_lane_memory.sv
// Word-addressed byte memory with per-lane write enables, one outstanding
// request, programmable response latency and out-of-range error reporting.
`default_nettype none

module byte_lane_memory #(
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned START      = 0,
    parameter int unsigned TOP        = 65535,
    parameter int unsigned LATENCY    = 2
) (
    input  logic               clk,
    input  logic               rst,
    byte_lane_memory_if.slave  bus
);

    localparam int unsigned AW    = $clog2(WORD_BYTES);
    localparam int unsigned DW    = WORD_BYTES * 8;
    localparam int unsigned DEPTH = (TOP - START + 1) / WORD_BYTES;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  req_ready_q;
    logic                  resp_valid_q;
    logic [DW-1:0]         rdata_q;
    logic                  err_q;

    logic [IDX_W-1:0]      idx_q;
    logic                  in_range_q;
    logic                  we_q;
    logic [WORD_BYTES-1:0] be_q;
    logic [DW-1:0]         wdata_q;

    logic [DW-1:0]         mem_q [DEPTH];

    // Address decode of the live request; 33-bit end address rules out wrap.
    logic [31:0]           req_ea;
    logic [32:0]           req_end;
    logic                  req_in_range;
    logic [31:0]           req_off;
    logic [IDX_W-1:0]      req_idx;
    logic                  unused_off;

    assign req_ea       = bus.req_addr & ~32'(WORD_BYTES - 1);
    assign req_end      = {1'b0, req_ea} + 33'(WORD_BYTES - 1);
    assign req_in_range = ({1'b0, req_ea} >= 33'(START)) && (req_end <= 33'(TOP));
    assign req_off      = req_ea - START;
    assign req_idx      = req_off[AW +: IDX_W];
    assign unused_off   = ^req_off;

    logic accept;
    logic commit;
    assign accept = (state_q == S_IDLE) && bus.req_valid;
    assign commit = ((state_q == S_IDLE) && accept && (LATENCY == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd0));

    // With zero latency the commit edge is also the accept edge, so the
    // live request is used instead of the (not yet loaded) capture registers.
    logic                  from_live;
    logic [IDX_W-1:0]      cm_idx;
    logic                  cm_in_range;
    logic                  cm_we;
    logic [WORD_BYTES-1:0] cm_be;
    logic [DW-1:0]         cm_wdata;

    assign from_live   = (state_q == S_IDLE);
    assign cm_idx      = from_live ? req_idx       : idx_q;
    assign cm_in_range = from_live ? req_in_range  : in_range_q;
    assign cm_we       = from_live ? bus.req_we    : we_q;
    assign cm_be       = from_live ? bus.req_be    : be_q;
    assign cm_wdata    = from_live ? bus.req_wdata : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            in_range_q   <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
        end else begin
            if (commit) begin
                rdata_q <= (cm_in_range && !cm_we) ? mem_q[cm_idx] : '0;
                err_q   <= !cm_in_range;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        idx_q       <= req_idx;
                        in_range_q  <= req_in_range;
                        we_q        <= bus.req_we;
                        be_q        <= bus.req_be;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && cm_in_range && cm_we) begin
            for (int l = 0; l < int'(WORD_BYTES); l++) begin
                if (cm_be[l]) begin
                    mem_q[cm_idx][8*l +: 8] <= cm_wdata[8*l +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_byte_lane_memory.sv
// Randomized bench for byte_lane_memory: three parameterisations share one
// stimulus bus and are checked against a byte-addressed reference model.
`default_nettype none

module tb_byte_lane_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        = 1'b0;
    int          sel        = 0;
    logic        req_valid  = 1'b0;
    logic        req_we     = 1'b0;
    logic [3:0]  req_be     = 4'h0;
    logic [31:0] req_addr   = 32'h0;
    logic [31:0] req_wdata  = 32'h0;
    logic        resp_ready = 1'b0;

    localparam longint ST [3] = '{64'h0,     64'h100, 64'h0};
    localparam longint TP [3] = '{64'hFFFF,  64'h1FF, 64'hFF};
    localparam int     LT [3] = '{2, 0, 3};

    byte_lane_memory_if #(.WORD_BYTES(4)) if0 ();
    byte_lane_memory_if #(.WORD_BYTES(4)) if1 ();
    byte_lane_memory_if #(.WORD_BYTES(4)) if2 ();

    assign if0.req_valid  = req_valid && (sel == 0);
    assign if0.req_we     = req_we;
    assign if0.req_be     = req_be;
    assign if0.req_addr   = req_addr;
    assign if0.req_wdata  = req_wdata;
    assign if0.resp_ready = resp_ready && (sel == 0);

    assign if1.req_valid  = req_valid && (sel == 1);
    assign if1.req_we     = req_we;
    assign if1.req_be     = req_be;
    assign if1.req_addr   = req_addr;
    assign if1.req_wdata  = req_wdata;
    assign if1.resp_ready = resp_ready && (sel == 1);

    assign if2.req_valid  = req_valid && (sel == 2);
    assign if2.req_we     = req_we;
    assign if2.req_be     = req_be;
    assign if2.req_addr   = req_addr;
    assign if2.req_wdata  = req_wdata;
    assign if2.resp_ready = resp_ready && (sel == 2);

    byte_lane_memory #(.WORD_BYTES(4), .START(32'h0),   .TOP(32'hFFFF), .LATENCY(2))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    byte_lane_memory #(.WORD_BYTES(4), .START(32'h100), .TOP(32'h1FF),  .LATENCY(0))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    byte_lane_memory #(.WORD_BYTES(4), .START(32'h0),   .TOP(32'hFF),   .LATENCY(3))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    always_comb begin
        o_ready = if0.req_ready;
        o_valid = if0.resp_valid;
        o_err   = if0.resp_err;
        o_rdata = if0.resp_rdata;
        case (sel)
            1: begin
                o_ready = if1.req_ready;  o_valid = if1.resp_valid;
                o_err   = if1.resp_err;   o_rdata = if1.resp_rdata;
            end
            2: begin
                o_ready = if2.req_ready;  o_valid = if2.resp_valid;
                o_err   = if2.resp_err;   o_rdata = if2.resp_rdata;
            end
            default: ;
        endcase
    end

    // Reference memory: one entry per (instance, byte address); absent = 0.
    byte unsigned mdl [longint];

    function automatic longint mkey(input int inst, input logic [31:0] a);
        return (longint'(inst) << 32) + longint'(a);
    endfunction

    function automatic byte unsigned mdl_rd(input longint k);
        if (mdl.exists(k)) return mdl[k];
        return 8'h00;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_idle_all(input string tag);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check({tag, "_ready"}, o_ready, 1);
            check({tag, "_valid"}, o_valid, 0);
            check({tag, "_rdata"}, o_rdata, 0);
            check({tag, "_err"},   o_err,   0);
        end
        sel = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mdl.delete();
    endtask

    // One full transaction; hold = cycles the response is back-pressured.
    task automatic txn(input int inst, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, output logic [31:0] got);
        logic [31:0] ea;
        bit          inr;
        logic [31:0] exp_d;
        int          k;
        sel   = inst;
        ea    = addr & 32'hFFFF_FFFC;
        inr   = (longint'(ea) >= ST[inst]) && (longint'(ea) + 3 <= TP[inst]);
        exp_d = 32'h0;
        for (int l = 0; l < 4; l++) begin
            if (inr && !we) exp_d[8*l +: 8] = mdl_rd(mkey(inst, ea + 32'(l)));
            if (inr && we && be[l]) mdl[mkey(inst, ea + 32'(l))] = wd[8*l +: 8];
        end
        #0;
        check("ready_idle", o_ready, 1);
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_be = 4'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        k = 0;
        while (!o_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, LT[inst]);
        check("ready_busy", o_ready, 0);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'($urandom);
            @(posedge clk); #1;
            check("hold_valid", o_valid, 1);
            check("hold_rdata", o_rdata, exp_d);
            check("hold_err",   o_err,   !inr);
            check("hold_ready", o_ready, 0);
        end
        req_valid = 1'b0;
        check("rdata", o_rdata, exp_d);
        check("err",   o_err,   !inr);
        got = o_rdata;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("valid_after_hs", o_valid, 0);
        check("ready_after_hs", o_ready, 1);
    endtask

    initial begin
        logic [31:0] got;
        do_reset();
        check_idle_all("reset");

        txn(0, 0, 4'h0, 32'h10, 32'h0, 0, got);
        check("plan_read10", got, 32'h0);
        txn(0, 1, 4'hF, 32'h20, 32'hDDCC_BBAA, 0, got);
        check("plan_wr_rdata_zero", got, 32'h0);
        txn(0, 0, 4'h0, 32'h23, 32'h0, 0, got);
        check("plan_read23", got, 32'hDDCC_BBAA);
        txn(0, 1, 4'h5, 32'h20, 32'h1122_3344, 0, got);
        txn(0, 0, 4'h0, 32'h20, 32'h0, 0, got);
        check("plan_merge", got, 32'hDD22_BB44);
        txn(0, 1, 4'h0, 32'h20, 32'hFFFF_FFFF, 0, got);
        txn(0, 0, 4'h0, 32'h20, 32'h0, 0, got);
        check("plan_be0", got, 32'hDD22_BB44);
        txn(0, 0, 4'h0, 32'h1_0000, 32'h0, 0, got);
        txn(0, 1, 4'hF, 32'h1_0000, 32'hCAFE_F00D, 0, got);
        txn(0, 1, 4'hF, 32'hFFFF_FFFE, 32'h1234_5678, 0, got);
        txn(0, 0, 4'h0, 32'hFFFC, 32'h0, 0, got);
        check("plan_top_untouched", got, 32'h0);
        txn(0, 1, 4'hF, 32'hFFFC, 32'h0BAD_BEEF, 0, got);
        txn(0, 0, 4'h0, 32'hFFFE, 32'h0, 5, got);
        check("plan_top_word", got, 32'h0BAD_BEEF);

        txn(1, 0, 4'h0, 32'hFC, 32'h0, 0, got);
        txn(1, 1, 4'hF, 32'h100, 32'hA5A5_5A5A, 0, got);
        txn(1, 1, 4'hA, 32'h1FC, 32'h8765_4321, 0, got);
        txn(1, 0, 4'h0, 32'h1FD, 32'h0, 5, got);
        check("plan_l0_top", got, 32'h8700_4300);
        txn(1, 0, 4'h0, 32'h100, 32'h0, 2, got);
        check("plan_l0_start", got, 32'hA5A5_5A5A);
        txn(1, 0, 4'h0, 32'h200, 32'h0, 1, got);

        txn(2, 1, 4'hF, 32'h80, 32'h0F0E_0D0C, 5, got);
        txn(2, 0, 4'h0, 32'h80, 32'h0, 5, got);
        check("plan_l3", got, 32'h0F0E_0D0C);

        for (int n = 0; n < 80; n++) begin
            int          inst;
            logic [31:0] a;
            inst = int'($urandom_range(0, 2));
            case ($urandom_range(0, 5))
                0:       a = 32'(ST[inst] - 4 + longint'($urandom_range(0, 7)));
                1:       a = 32'(TP[inst] - 7 + longint'($urandom_range(0, 15)));
                default: a = 32'(ST[inst] + longint'($urandom_range(0, 47)));
            endcase
            txn(inst, 1'($urandom), 4'($urandom), a, $urandom,
                int'($urandom_range(0, 3)), got);
        end

        // Reset while a write waits: response and write must both vanish.
        sel = 0;
        txn(0, 1, 4'hF, 32'h40, 32'h1357_9BDF, 0, got);
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
        req_addr = 32'h40; req_wdata = 32'hFEED_FACE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_ready", o_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mdl.delete();
        check_idle_all("midrst");
        txn(0, 0, 4'h0, 32'h40, 32'h0, 0, got);
        check("midrst_read40", got, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
